// File: rtl/regfile_rsp_pkg.sv
// ---------------------------------------------------------------------------
// regfile_rsp_pkg
// Shared constants for the general-purpose register file: bus widths,
// register count, zero constants, enable levels and the clear-sequencer
// state encodings.
// ---------------------------------------------------------------------------
package regfile_rsp_pkg;

    localparam int RegBus     = 32;  // register data width
    localparam int RegAddrBus = 5;   // register address width
    localparam int RegNum     = 32;  // architectural register count
    localparam int RegNumLog2 = 5;   // log2(RegNum)

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;  // $0, hard-wired zero

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    // Clear-sequencer state encodings
    localparam logic [0:0] RF_INIT = 1'b0;
    localparam logic [0:0] RF_RUN  = 1'b1;

endpackage

// File: rtl/regfile_clr_seq.sv
// ---------------------------------------------------------------------------
// regfile_clr_seq
// Post-reset clear sequencer. After every reset it walks r1..r(REG_NUM-1),
// issuing one zero-write per cycle, and holds busy_o high until the last
// register has been cleared. With INIT_CLEAR=0 it goes straight to RUN.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   busy_o      clear sequence in progress (also high during rst if clearing)
//   clr_we_o    array write strobe for the clear write
//   clr_addr_o  register being cleared this cycle
// ---------------------------------------------------------------------------
module regfile_clr_seq
    import regfile_rsp_pkg::*;
#(
    parameter int REG_NUM    = RegNum,
    parameter int ADDR_W     = RegNumLog2,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(REG_NUM - 1);
    localparam logic [ADDR_W-1:0] FirstIdx   = ADDR_W'(1);
    localparam logic [0:0]        ResetState = (INIT_CLEAR != 0) ? RF_INIT : RF_RUN;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == RF_INIT) begin
            // Stop on the last index instead of incrementing past it, so the
            // counter never wraps back onto $0.
            if (clr_cnt_q == LastIdx) begin
                state_d = RF_RUN;
            end else begin
                clr_cnt_d = clr_cnt_q + FirstIdx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ResetState;
            clr_cnt_q <= FirstIdx;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // During reset the state register is not yet meaningful; report the
    // state reset will land in so the pipeline is already held off.
    assign busy_o     = rst ? (ResetState == RF_INIT) : (state_q == RF_INIT);
    assign clr_we_o   = !rst && (state_q == RF_INIT);
    assign clr_addr_o = clr_cnt_q;

endmodule

// File: rtl/regfile_rsp.sv
// ---------------------------------------------------------------------------
// regfile_rsp
// 32 x 32-bit general-purpose register file: two combinational read ports
// for decode (reg1/reg2) and one write port from write-back. Reads bypass the
// same-cycle write-back value; $0 always reads zero and is never written.
// After reset the file clears itself and stalls the pipeline via busy_o.
//
// Ports:
//   clk, rst              clock / synchronous active-high reset
//   we, waddr, wdata      write-back port
//   re1, raddr1, rdata1   read port 1 (decode reg1_read)
//   re2, raddr2, rdata2   read port 2 (decode reg2_read)
//   busy_o                clear sequence running; pipeline must stall
// ---------------------------------------------------------------------------
module regfile_rsp
    import regfile_rsp_pkg::*;
#(
    parameter int REG_NUM    = RegNum,
    parameter int ADDR_W     = RegNumLog2,
    parameter int DATA_W     = RegBus,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(NOPRegAddr);
    localparam logic [DATA_W-1:0] ZeroData = DATA_W'(ZeroWord);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wb_we;
    logic              read_ok;

    // Entry 0 exists only to keep indexing simple; it is never written and
    // never observable because address 0 reads short-circuit to zero.
    logic [DATA_W-1:0] mem_q [0:REG_NUM-1];

    regfile_clr_seq #(
        .REG_NUM    (REG_NUM),
        .ADDR_W     (ADDR_W),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .busy_o     (busy_o),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Write-back is dropped while resetting or clearing.
    assign wb_we   = (we == Enable) && (waddr != ZeroAddr) && !busy_o && !rst;
    assign read_ok = !rst && !busy_o;

    // NOTE: the array has no reset branch; clearing is done one entry per
    // cycle by the sequencer so the storage maps onto plain RAM/flops
    // without a wide reset fan-out.
    always_ff @(posedge clk) begin
        if (clr_we && (clr_addr != ZeroAddr)) begin
            mem_q[clr_addr] <= ZeroData;
        end else if (wb_we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = ZeroData;
        if (read_ok && (raddr1 != ZeroAddr) && (re1 == Enable)) begin
            if ((we == Enable) && (waddr == raddr1)) begin
                rdata1 = wdata;  // write-first bypass
            end else begin
                rdata1 = mem_q[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = ZeroData;
        if (read_ok && (raddr2 != ZeroAddr) && (re2 == Enable)) begin
            if ((we == Enable) && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem_q[raddr2];
            end
        end
    end

    // Disable is the idle level for the write-back enable; kept for
    // readability of the shared constant set.
    logic unused_disable;
    assign unused_disable = Disable;

endmodule

// File: doc/regfile_rsp.md
Name: regfile_rsp

Overview:
- General-purpose register file: 32 x 32-bit registers, with two read ports answering the decode stage's reg1/reg2 read requests and one write port fed by write-back.
- Combinational read path with write-first bypass from the same-cycle write-back; $0 reads as zero.
- After every reset, a sequencer clears r1..r31 one per cycle, and the file holds off the pipeline via busy_o.

Parameters:
- REG_NUM, 32, number of architectural registers; power of two.
- ADDR_W, 5, register address width; log2(REG_NUM).
- DATA_W, 32, register width.
- INIT_CLEAR, 1, 1 = run the clear sequence after reset; 0 = enter RUN directly and keep contents through reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset.
- we  in  1  write-back write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re1  in  1  read-port-1 request (decode reg1_read).
- raddr1  in  ADDR_W  read-port-1 address.
- rdata1  out  DATA_W  read-port-1 data, combinational.
- re2  in  1  read-port-2 request (decode reg2_read).
- raddr2  in  ADDR_W  read-port-2 address.
- rdata2  out  DATA_W  read-port-2 data, combinational.
- busy_o  out  1  high while the clear sequence runs; the pipeline stalls.

Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- State machine: INIT, RUN. On a clk edge with rst=1: state <= INIT (RUN if INIT_CLEAR=0), clr_cnt <= 1, no array write.
- INIT:
  - Each cycle mem[clr_cnt] <= 0 and clr_cnt++.
  - On the cycle that writes index REG_NUM-1, next state = RUN.
  - busy_o=1 for exactly REG_NUM-1 (31) cycles after the first cycle with rst=0.
- RUN: busy_o=0. If we=1 and waddr!=0, mem[waddr] <= wdata at the edge. Writes to $0 are ignored.
- Writes during INIT or while rst=1 are dropped; write-back is stalled by busy_o.
- Read port n, combinational, first match wins:
  1. rst=1 or busy_o=1 -> 0.
  2. raddr==0 -> 0.
  3. re=1, we=1, waddr==raddr -> wdata (bypass).
  4. re=1 -> mem[raddr].
  5. re=0 -> 0.
- Both read ports are independent and may hit the same address, including the bypassed one.
- Reset values: rdata1=0, rdata2=0, busy_o=1 while rst=1. With INIT_CLEAR=0, busy_o=0.
- Reset mid-INIT restarts the sequence from clr_cnt=1 (full 31 cycles). Reset mid-RUN re-clears all registers.
- clr_cnt is ADDR_W wide. The terminal check is clr_cnt==REG_NUM-1, so the counter never wraps.
- $0 is never stored; mem[0] may be omitted.

Decomposition:
- Shared defines file: RegBus, RegAddrBus, RegNum, RegNumLog2, ZeroWord, NOPRegAddr, Enable/Disable, and state encodings RF_INIT/RF_RUN.
- One natural sub-module: regfile_clr_seq, holding the FSM and clr_cnt. It outputs busy, clr_we and clr_addr; the top muxes the array write port between it and write-back.

Test Plan:
- Clear sequence: rst=1 for 2 cycles then 0 -> busy_o=1 for 31 cycles then 0. A read of raddr1=31 with re1=1 returns 0 after busy_o falls.
- Write then read: write r5=0xDEADBEEF, next cycle re1=1, raddr1=5 -> rdata1=0xDEADBEEF; re1=0 -> rdata1=0.
- Bypass: same cycle we=1, waddr=7, wdata=0x12345678, re2=1, raddr2=7 -> rdata2=0x12345678 before the edge, and mem[7] holds it after the edge.
- $0: we=1, waddr=0, wdata=0xFFFFFFFF, then read raddr1=0 and raddr2=0 with re=1 (including the same-cycle bypass case) -> both return 0.
- Mid-run reset: write r3=0xA5A5A5A5, pulse rst for 1 cycle -> busy_o high 31 cycles. Writes to r4 issued during busy are dropped; reading r3 and r4 afterwards returns 0.
- Reset mid-INIT: assert rst at busy cycle 10 -> count restarts and busy_o lasts 31 cycles after rst falls.
